// File: rtl/pll_lock_manager.sv
// Supervises NUM_PLLS PLLs: lock synchronisation/debounce, reset pulsing with retry/fault,
// and staggered in-order release of the per-domain resets.
module pll_lock_manager #(
    parameter int unsigned NUM_PLLS            = 2,
    parameter int unsigned RESET_PULSE_CYCLES  = 25,
    parameter int unsigned LOCK_STABLE_CYCLES  = 2500,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 250000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned STAGGER_CYCLES      = 16
) (
    input  logic                clk_25mhz,
    input  logic                rst,
    input  logic [NUM_PLLS-1:0] pll_lock_raw,
    input  logic                clear_fault,
    output logic [NUM_PLLS-1:0] pll_rst,
    output logic [NUM_PLLS-1:0] domain_rst,
    output logic                all_ready,
    output logic [NUM_PLLS-1:0] fault
);

    localparam int unsigned RPW = $clog2(RESET_PULSE_CYCLES + 1);
    localparam int unsigned SW  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned TW  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned RTW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned GW  = (STAGGER_CYCLES > 0) ? $clog2(STAGGER_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    logic [NUM_PLLS-1:0] sync_meta;
    logic [NUM_PLLS-1:0] lock_s;

    // Two-stage synchroniser for the asynchronous lock inputs
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            lock_s    <= '0;
        end else begin
            sync_meta <= pll_lock_raw;
            lock_s    <= sync_meta;
        end
    end

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) all_ready <= 1'b0;
        else     all_ready <= ~|domain_rst;
    end

    for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [RPW-1:0]   rcnt_q, rcnt_d;
        logic [SW-1:0]    scnt_q, scnt_d;
        logic [TW-1:0]    tcnt_q, tcnt_d;
        logic [RTW-1:0]   retry_q, retry_d;
        logic [RTW:0]     retry_inc;
        logic             attempt_failed;
        logic             stagger_ok;
        logic             release_ok;
        logic             pll_rst_q, fault_q, drst_q;

        assign retry_inc = {1'b0, retry_q} + (RTW + 1)'(1);

        always_comb begin
            state_d        = state_q;
            rcnt_d         = rcnt_q;
            scnt_d         = scnt_q;
            tcnt_d         = tcnt_q;
            retry_d        = retry_q;
            attempt_failed = 1'b0;
            case (state_q)
                ST_RESET: begin
                    if (rcnt_q == RPW'(RESET_PULSE_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        rcnt_d  = '0;
                        scnt_d  = '0;
                        tcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RPW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    tcnt_d = tcnt_q + TW'(1);
                    scnt_d = lock_s[i] ? scnt_q + SW'(1) : '0;
                    // Lock completion takes priority over a coincident timeout
                    if (lock_s[i] && (scnt_q == SW'(LOCK_STABLE_CYCLES - 1))) begin
                        state_d = ST_LOCKED;
                        retry_d = '0;
                    end else if (tcnt_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        attempt_failed = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!lock_s[i]) attempt_failed = 1'b1;
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        state_d = ST_RESET;
                        retry_d = '0;
                        rcnt_d  = '0;
                    end
                end
                default: state_d = ST_RESET;
            endcase
            if (attempt_failed) begin
                rcnt_d = '0;
                if (retry_inc > (RTW + 1)'(MAX_RETRIES)) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_RESET;
                    retry_d = RTW'(retry_inc);
                end
            end
        end

        // Gap counter: cycles the previous domain has been out of reset
        if (i == 0) begin : g_first
            assign stagger_ok = 1'b1;
        end else begin : g_gap
            logic [GW-1:0] gap_q;
            always_ff @(posedge clk_25mhz or posedge rst) begin
                if (rst)                             gap_q <= '0;
                else if (domain_rst[i-1])            gap_q <= '0;
                else if (gap_q != GW'(STAGGER_CYCLES)) gap_q <= gap_q + GW'(1);
            end
            assign stagger_ok = !domain_rst[i-1] && (gap_q >= GW'(STAGGER_CYCLES));
        end

        // Losing lock in LOCKED drops release_ok, so domain_rst reasserts with the state change
        assign release_ok = (state_q == ST_LOCKED) && lock_s[i] && stagger_ok;

        always_ff @(posedge clk_25mhz or posedge rst) begin
            if (rst) begin
                state_q   <= ST_RESET;
                rcnt_q    <= '0;
                scnt_q    <= '0;
                tcnt_q    <= '0;
                retry_q   <= '0;
                pll_rst_q <= 1'b1;
                fault_q   <= 1'b0;
                drst_q    <= 1'b1;
            end else begin
                state_q   <= state_d;
                rcnt_q    <= rcnt_d;
                scnt_q    <= scnt_d;
                tcnt_q    <= tcnt_d;
                retry_q   <= retry_d;
                pll_rst_q <= (state_d == ST_RESET) || (state_d == ST_FAULT);
                fault_q   <= (state_d == ST_FAULT);
                drst_q    <= !release_ok;
            end
        end

        assign pll_rst[i]    = pll_rst_q;
        assign fault[i]      = fault_q;
        assign domain_rst[i] = drst_q;
    end

endmodule

// File: tb/tb_pll_lock_manager.sv
// Directed bench for pll_lock_manager: expected output transitions are queued with their
// cycle windows when stimulus is applied, then popped and matched against the outputs.
module tb_pll_lock_manager;

    localparam int S_PR0 = 0;
    localparam int S_PR1 = 1;
    localparam int S_DR0 = 2;
    localparam int S_DR1 = 3;
    localparam int S_AR  = 4;
    localparam int S_FT0 = 5;
    localparam int S_FT1 = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] lock_raw;
    logic       clear_fault;
    logic [1:0] pll_rst;
    logic [1:0] domain_rst;
    logic       all_ready;
    logic [1:0] fault;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    sel;
        logic  val;
        int    lo;
        int    hi;
    } evt_t;

    evt_t exp_q[$];

    pll_lock_manager #(
        .NUM_PLLS           (2),
        .RESET_PULSE_CYCLES (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(64),
        .MAX_RETRIES        (2),
        .STAGGER_CYCLES     (3)
    ) dut (
        .clk_25mhz   (clk),
        .rst         (rst),
        .pll_lock_raw(lock_raw),
        .clear_fault (clear_fault),
        .pll_rst     (pll_rst),
        .domain_rst  (domain_rst),
        .all_ready   (all_ready),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic sig(input int sel);
        case (sel)
            S_PR0:   return pll_rst[0];
            S_PR1:   return pll_rst[1];
            S_DR0:   return domain_rst[0];
            S_DR1:   return domain_rst[1];
            S_AR:    return all_ready;
            S_FT0:   return fault[0];
            S_FT1:   return fault[1];
            default: return 1'bx;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic val, input int lo, input int hi);
        evt_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        e.lo  = lo;
        e.hi  = hi;
        exp_q.push_back(e);
    endtask

    // Pop the oldest expected transition and wait (bounded) for it
    task automatic observe(output int at);
        evt_t e;
        logic hit;
        e = exp_q.pop_front();
        while (sig(e.sel) !== e.val && cyc < e.hi) @(negedge clk);
        hit = (sig(e.sel) === e.val) && (cyc >= e.lo) && (cyc <= e.hi);
        at  = cyc;
        checks++;
        assert (hit === 1'b1)
        else begin
            errors++;
            $error("FAIL %s: observed level %b at cycle %0d, expected %b within cycles %0d..%0d",
                   e.tag, sig(e.sel), cyc, e.val, e.lo, e.hi);
        end
    endtask

    // Release rst and run the nominal bring-up of both channels
    task automatic nominal(input string pfx);
        int c0, l, at;
        rst = 1'b0;
        c0  = cyc;
        push({pfx, "_pll_rst0_fall"}, S_PR0, 1'b0, c0 + 4, c0 + 4);
        observe(at);
        chk({pfx, "_pll_rst_both_low"}, 8'(pll_rst), 8'h00);
        lock_raw = 2'b11;
        l = cyc;
        push({pfx, "_domain_rst0_fall"}, S_DR0, 1'b0, l + 11, l + 11);
        push({pfx, "_domain_rst1_fall"}, S_DR1, 1'b0, l + 14, l + 15);
        observe(at);
        observe(at);
        push({pfx, "_all_ready_rise"}, S_AR, 1'b1, at + 1, at + 1);
        observe(at);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, l, at, f_exp, r_exp, k, d, w;

        rst         = 1'b1;
        lock_raw    = 2'b00;
        clear_fault = 1'b0;
        step(3);

        // Reset values
        chk("rst_pll_rst", 8'(pll_rst), 8'h03);
        chk("rst_domain_rst", 8'(domain_rst), 8'h03);
        chk("rst_all_ready", 8'(all_ready), 8'h00);
        chk("rst_fault", 8'(fault), 8'h00);

        // 1: nominal start
        nominal("t1");
        chk("t1_fault", 8'(fault), 8'h00);

        // 2: glitchy lock on channel 0
        rst      = 1'b1;
        lock_raw = 2'b00;
        step(3);
        rst = 1'b0;
        c0  = cyc;
        push("t2_pll_rst0_fall", S_PR0, 1'b0, c0 + 4, c0 + 4);
        observe(at);
        l = cyc;
        lock_raw = 2'b11;
        push("t2_domain_rst0_fall", S_DR0, 1'b0, l + 18, l + 18);
        push("t2_domain_rst1_fall", S_DR1, 1'b0, l + 21, l + 22);
        step(6);
        lock_raw[0] = 1'b0;
        step(1);
        lock_raw[0] = 1'b1;
        observe(at);
        observe(at);
        push("t2_all_ready_rise", S_AR, 1'b1, at + 1, at + 1);
        observe(at);

        // 3: timeout and fault on channel 1
        rst      = 1'b1;
        lock_raw = 2'b00;
        step(3);
        rst = 1'b0;
        c0  = cyc;
        push("t3_pll_rst0_fall", S_PR0, 1'b0, c0 + 4, c0 + 4);
        push("t3_pll_rst1_fall", S_PR1, 1'b0, c0 + 4, c0 + 4);
        observe(at);
        observe(at);
        lock_raw = 2'b01;
        l = cyc;
        push("t3_domain_rst0_fall", S_DR0, 1'b0, l + 11, l + 11);
        observe(at);
        f_exp = c0 + 4;
        r_exp = f_exp;
        for (int a = 0; a < 3; a++) begin
            r_exp = f_exp + 64;
            push($sformatf("t3_pll_rst1_rise_%0d", a), S_PR1, 1'b1, r_exp, r_exp);
            observe(at);
            if (a < 2) begin
                f_exp = r_exp + 4;
                push($sformatf("t3_pll_rst1_fall_%0d", a), S_PR1, 1'b0, f_exp, f_exp);
                observe(at);
            end
        end
        push("t3_fault1_rise", S_FT1, 1'b1, r_exp, r_exp);
        observe(at);
        chk("t3_fault", 8'(fault), 8'h02);
        chk("t3_pll_rst", 8'(pll_rst), 8'h02);
        chk("t3_domain_rst", 8'(domain_rst), 8'h02);
        chk("t3_all_ready", 8'(all_ready), 8'h00);
        step(5);
        chk("t3_fault_held", 8'(fault), 8'h02);
        chk("t3_pll_rst_held", 8'(pll_rst), 8'h02);

        // 3b: clear_fault recovers channel 1
        k = cyc;
        lock_raw    = 2'b11;
        clear_fault = 1'b1;
        push("t3_fault1_fall", S_FT1, 1'b0, k + 1, k + 1);
        push("t3_rec_pll_rst1_fall", S_PR1, 1'b0, k + 5, k + 5);
        push("t3_rec_domain_rst1_fall", S_DR1, 1'b0, k + 14, k + 14);
        step(1);
        clear_fault = 1'b0;
        chk("t3_clear_pll_rst", 8'(pll_rst), 8'h02);
        observe(at);
        observe(at);
        observe(at);
        push("t3_rec_all_ready_rise", S_AR, 1'b1, at + 1, at + 1);
        observe(at);
        chk("t3_rec_fault", 8'(fault), 8'h00);

        // 4: loss of lock on channel 0 cascades into domain 1
        step(5);
        d = cyc;
        lock_raw[0] = 1'b0;
        push("t4_pll_rst0_rise", S_PR0, 1'b1, d + 3, d + 3);
        push("t4_domain_rst0_rise", S_DR0, 1'b1, d + 3, d + 3);
        push("t4_domain_rst1_rise", S_DR1, 1'b1, d + 4, d + 4);
        push("t4_all_ready_fall", S_AR, 1'b0, d + 4, d + 4);
        push("t4_pll_rst0_fall", S_PR0, 1'b0, d + 7, d + 7);
        push("t4_domain_rst0_fall", S_DR0, 1'b0, d + 16, d + 16);
        push("t4_domain_rst1_fall", S_DR1, 1'b0, d + 19, d + 20);
        step(1);
        lock_raw[0] = 1'b1;
        for (int n = 0; n < 7; n++) observe(at);
        push("t4_all_ready_rise", S_AR, 1'b1, at + 1, at + 1);
        observe(at);
        chk("t4_pll_rst1_untouched", 8'(pll_rst), 8'h00);

        // 5: stable completion coincides with the last timeout cycle
        rst      = 1'b1;
        lock_raw = 2'b00;
        step(3);
        rst = 1'b0;
        c0  = cyc;
        w   = c0 + 4;
        push("t5_pll_rst0_fall", S_PR0, 1'b0, w, w);
        observe(at);
        step(w + 54 - cyc);
        lock_raw[0] = 1'b1;
        push("t5_pll_rst1_timeout_rise", S_PR1, 1'b1, w + 64, w + 64);
        push("t5_domain_rst0_fall", S_DR0, 1'b0, w + 65, w + 65);
        observe(at);
        chk("t5_pll_rst_lock_wins", 8'(pll_rst), 8'h02);
        observe(at);
        chk("t5_fault", 8'(fault), 8'h00);

        // 6: asynchronous reset with ch0 LOCKED and ch1 in WAIT_LOCK
        step(5);
        chk("t6_pre_domain_rst", 8'(domain_rst), 8'h02);
        chk("t6_pre_pll_rst", 8'(pll_rst), 8'h00);
        #2;
        rst      = 1'b1;
        lock_raw = 2'b00;
        #1;
        chk("t6_async_pll_rst", 8'(pll_rst), 8'h03);
        chk("t6_async_domain_rst", 8'(domain_rst), 8'h03);
        chk("t6_async_fault", 8'(fault), 8'h00);
        chk("t6_async_all_ready", 8'(all_ready), 8'h00);
        @(negedge clk);
        step(2);
        nominal("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
